mem_stage: RTL

Memory stage of the five-stage MIPS pipeline. It captures the execute-stage results (ALU result, store data, instruction, PC, PC+4, RegWrite) into the EX/MEM pipeline register and uses them to access an internal 4 KiB data memory. It executes word, halfword and byte stores, and word, halfword and byte loads with sign or zero extension. Its outputs go to the write-back stage.

---
 rtl/mem_stage.sv | 201 ++++++++++++++++++++
 1 files changed

// File: rtl/mem_stage.sv
// MIPS memory stage: EX/MEM pipeline register plus a word-addressed data memory
// serving byte/halfword/word loads and stores with alignment checking.
module mem_stage #(
   parameter int unsigned DEPTH_WORDS = 1024
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        stall,
   input  logic        flush,
   input  logic [31:0] PC_2,
   input  logic [31:0] PC4_2,
   input  logic [31:0] Instr_2,
   input  logic [31:0] ALU_Out_2,
   input  logic [31:0] RD2_2,
   input  logic        RegWrite_2,
   output logic [31:0] PC_3,
   output logic [31:0] PC4_3,
   output logic [31:0] Instr_3,
   output logic [31:0] ALU_Out_3,
   output logic [31:0] MemRD_3,
   output logic        RegWrite_3,
   output logic        AdEL_3,
   output logic        AdES_3
);

   localparam int unsigned IdxW = $clog2(DEPTH_WORDS);

   localparam logic [5:0] OpLb  = 6'h20;
   localparam logic [5:0] OpLh  = 6'h21;
   localparam logic [5:0] OpLw  = 6'h23;
   localparam logic [5:0] OpLbu = 6'h24;
   localparam logic [5:0] OpLhu = 6'h25;
   localparam logic [5:0] OpSb  = 6'h28;
   localparam logic [5:0] OpSh  = 6'h29;
   localparam logic [5:0] OpSw  = 6'h2B;

   typedef enum logic [1:0] {SzByte, SzHalf, SzWord} size_e;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] pc4;
      logic [31:0] instr;
      logic [31:0] alu;
      logic [31:0] rd2;
      logic        regwrite;
   } exmem_t;

   exmem_t ex_q, ex_d;

   // ---------------------------------------------------------------------------
   // EX/MEM pipeline register: reset/flush load a bubble, stall holds
   // ---------------------------------------------------------------------------
   always_comb begin
      ex_d = ex_q;
      if (reset || flush) begin
         ex_d = '0;
      end else if (!stall) begin
         ex_d.pc       = PC_2;
         ex_d.pc4      = PC4_2;
         ex_d.instr    = Instr_2;
         ex_d.alu      = ALU_Out_2;
         ex_d.rd2      = RD2_2;
         ex_d.regwrite = RegWrite_2;
      end
   end

   always_ff @(posedge clk) begin
      ex_q <= ex_d;
   end

   // ---------------------------------------------------------------------------
   // Decode
   // ---------------------------------------------------------------------------
   logic [5:0] opcode;
   logic       is_load;
   logic       is_store;
   logic       sign_ext;
   size_e      acc_size;
   logic       misaligned;

   assign opcode = ex_q.instr[31:26];

   always_comb begin
      is_load  = 1'b0;
      is_store = 1'b0;
      sign_ext = 1'b0;
      acc_size = SzWord;
      case (opcode)
         OpLw:  begin is_load  = 1'b1; acc_size = SzWord; end
         OpLh:  begin is_load  = 1'b1; acc_size = SzHalf; sign_ext = 1'b1; end
         OpLhu: begin is_load  = 1'b1; acc_size = SzHalf; end
         OpLb:  begin is_load  = 1'b1; acc_size = SzByte; sign_ext = 1'b1; end
         OpLbu: begin is_load  = 1'b1; acc_size = SzByte; end
         OpSw:  begin is_store = 1'b1; acc_size = SzWord; end
         OpSh:  begin is_store = 1'b1; acc_size = SzHalf; end
         OpSb:  begin is_store = 1'b1; acc_size = SzByte; end
         default: ;
      endcase
   end

   always_comb begin
      misaligned = 1'b0;
      case (acc_size)
         SzWord:  misaligned = (ex_q.alu[1:0] != 2'b00);
         SzHalf:  misaligned = ex_q.alu[0];
         default: misaligned = 1'b0;
      endcase
   end

   assign AdEL_3 = is_load && misaligned;
   assign AdES_3 = is_store && misaligned;

   // ---------------------------------------------------------------------------
   // Data memory
   // ---------------------------------------------------------------------------
   logic [31:0]     mem_q [DEPTH_WORDS];
   logic [IdxW-1:0] mem_idx;
   logic [31:0]     rd_word;
   logic [31:0]     wr_word;
   logic [3:0]      st_be;
   logic [31:0]     st_lanes;
   logic            mem_we;

   // Upper address bits are dropped, so accesses wrap within the memory
   assign mem_idx = ex_q.alu[IdxW+1:2];
   assign rd_word = mem_q[mem_idx];
   assign mem_we  = is_store && !misaligned && !reset;

   always_comb begin
      st_be    = 4'b0000;
      st_lanes = ex_q.rd2;
      case (acc_size)
         SzWord: st_be = 4'b1111;
         SzHalf: begin
            st_be    = ex_q.alu[1] ? 4'b1100 : 4'b0011;
            st_lanes = {2{ex_q.rd2[15:0]}};
         end
         SzByte: begin
            case (ex_q.alu[1:0])
               2'b00:   st_be = 4'b0001;
               2'b01:   st_be = 4'b0010;
               2'b10:   st_be = 4'b0100;
               default: st_be = 4'b1000;
            endcase
            st_lanes = {4{ex_q.rd2[7:0]}};
         end
         default: st_be = 4'b0000;
      endcase
   end

   // Read-modify-write merge keeps unselected bytes intact
   always_comb begin
      wr_word = rd_word;
      for (int b = 0; b < 4; b++) begin
         if (st_be[b]) begin
            wr_word[8*b +: 8] = st_lanes[8*b +: 8];
         end
      end
   end

   for (genvar w = 0; w < DEPTH_WORDS; w++) begin : g_mem
      always_ff @(posedge clk) begin
         if (reset) begin
            mem_q[w] <= '0;
         end else if (mem_we && (mem_idx == IdxW'(w))) begin
            mem_q[w] <= wr_word;
         end
      end
   end

   // ---------------------------------------------------------------------------
   // Load extraction and extension
   // ---------------------------------------------------------------------------
   logic [15:0] ld_half;
   logic [7:0]  ld_byte;
   logic [31:0] ld_val;

   assign ld_half = ex_q.alu[1] ? rd_word[31:16] : rd_word[15:0];
   assign ld_byte = rd_word[{ex_q.alu[1:0], 3'b000} +: 8];

   always_comb begin
      ld_val = rd_word;
      case (acc_size)
         SzHalf:  ld_val = {{16{sign_ext & ld_half[15]}}, ld_half};
         SzByte:  ld_val = {{24{sign_ext & ld_byte[7]}}, ld_byte};
         default: ld_val = rd_word;
      endcase
   end

   assign MemRD_3 = (is_load && !misaligned) ? ld_val : 32'h0;

   // ---------------------------------------------------------------------------
   // Outputs to write-back
   // ---------------------------------------------------------------------------
   assign PC_3       = ex_q.pc;
   assign PC4_3      = ex_q.pc4;
   assign Instr_3    = ex_q.instr;
   assign ALU_Out_3  = ex_q.alu;
   assign RegWrite_3 = ex_q.regwrite && !AdEL_3;

endmodule
